mm_interrupt_controller: RTL

- Memory-mapped external interrupt controller, PLIC-lite.
- Sits directly upstream of the privileged core's m_ext_interrupt / s_ext_interrupt inputs.
- Latches level interrupt sources into pending bits and masks them per privilege context.
- Exposes claim/complete registers on the data-memory bus, alongside the timer, UART and SW interrupt register.

---
 rtl/mm_interrupt_controller.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mm_interrupt_controller.sv
// mm_interrupt_controller: PLIC-lite external interrupt controller.
// Level sources latch into pending bits. Pending bits are masked per context (M and S).
// Claim reads return the lowest enabled pending ID and move that ID to in_flight.
// A complete write retires the ID, after which a still-asserted source can pend again.
// Optional macro MM_INTERRUPT_CONTROLLER_SYNC_EN adds a 2-flop input synchronizer.
module mm_interrupt_controller #(
    parameter int unsigned           DATA_WIDTH  = 64,
    parameter int unsigned           ADDR_WIDTH  = 64,
    parameter int unsigned           NUM_SOURCES = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(64'h000F0000)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_SOURCES-1:0]  irq_sources,
    input  logic                    readEnable,
    input  logic                    writeEnable,
    input  logic [DATA_WIDTH/8-1:0] writeByteEnable,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   writeData,
    output logic [DATA_WIDTH-1:0]   readData,
    output logic                    m_ext_interrupt,
    output logic                    s_ext_interrupt
);

    localparam logic [ADDR_WIDTH-1:0] OffPending = ADDR_WIDTH'(8'h00);
    localparam logic [ADDR_WIDTH-1:0] OffMEnable = ADDR_WIDTH'(8'h08);
    localparam logic [ADDR_WIDTH-1:0] OffSEnable = ADDR_WIDTH'(8'h10);
    localparam logic [ADDR_WIDTH-1:0] OffMClaim  = ADDR_WIDTH'(8'h18);
    localparam logic [ADDR_WIDTH-1:0] OffSClaim  = ADDR_WIDTH'(8'h20);

    // Vectors are indexed by ID; bit 0 (ID "none") is always 0.
    logic [NUM_SOURCES:0]  pending_q, pending_d;
    logic [NUM_SOURCES:0]  in_flight_q, in_flight_d;
    logic [NUM_SOURCES:0]  m_enable_q, m_enable_d;
    logic [NUM_SOURCES:0]  s_enable_q, s_enable_d;
    logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
    logic                  m_ext_q, m_ext_d;
    logic                  s_ext_q, s_ext_d;

    logic [ADDR_WIDTH-1:0]  offset;
    logic [NUM_SOURCES-1:0] gw_src;
    logic [7:0]             m_claim_id;
    logic [7:0]             s_claim_id;
    logic [7:0]             complete_id;
    logic                   m_claim_rd, s_claim_rd;
    logic                   m_complete_wr, s_complete_wr;

    assign offset      = address - BASE_ADDR;
    assign complete_id = writeData[7:0];

    // Bits above NUM_SOURCES and unused byte lanes are intentionally dropped.
    logic unused_bus;
    assign unused_bus = ^{writeData, writeByteEnable};

`ifdef MM_INTERRUPT_CONTROLLER_SYNC_EN
    logic [NUM_SOURCES-1:0] sync1_q, sync1_d;
    logic [NUM_SOURCES-1:0] sync2_q, sync2_d;

    // Synchronizer chain next-state.
    always_comb begin
        sync1_d = irq_sources;
        sync2_d = sync1_q;
    end

    // Two-flop synchronizer for asynchronous sources.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign gw_src = sync2_q;
`else
    assign gw_src = irq_sources;
`endif

    // Lowest set ID in the vector, or 0 when empty.
    function automatic logic [7:0] lowest_id(input logic [NUM_SOURCES:0] v);
        logic [7:0] id;
        id = '0;
        for (int i = NUM_SOURCES; i >= 1; i--) begin
            if (v[i]) id = 8'(i);
        end
        return id;
    endfunction

    // Byte-lane masked enable update; bit 0 stays 0.
    function automatic logic [NUM_SOURCES:0] enable_write(input logic [NUM_SOURCES:0] old_v,
                                                          input logic [DATA_WIDTH-1:0] wdata,
                                                          input logic [DATA_WIDTH/8-1:0] be);
        logic [NUM_SOURCES:0] r;
        r = old_v;
        for (int i = 1; i <= NUM_SOURCES; i++) begin
            if (be[i/8]) r[i] = wdata[i];
        end
        r[0] = 1'b0;
        return r;
    endfunction

    // Decode claim/complete strobes and select the per-context claim candidates.
    always_comb begin
        m_claim_id    = lowest_id(pending_q & m_enable_q);
        s_claim_id    = lowest_id(pending_q & s_enable_q);
        m_claim_rd    = readEnable && (offset == OffMClaim);
        s_claim_rd    = readEnable && (offset == OffSClaim);
        m_complete_wr = writeEnable && writeByteEnable[0] && (offset == OffMClaim);
        s_complete_wr = writeEnable && writeByteEnable[0] && (offset == OffSClaim);
    end

    // Gateway, claim and complete updates of pending/in_flight; enable writes.
    always_comb begin
        pending_d   = pending_q;
        in_flight_d = in_flight_q;
        m_enable_d  = m_enable_q;
        s_enable_d  = s_enable_q;

        for (int i = 1; i <= NUM_SOURCES; i++) begin
            // Gateway uses pre-edge state, so a completion re-pends one cycle later.
            if (gw_src[i-1] && !pending_q[i] && !in_flight_q[i]) pending_d[i] = 1'b1;
            if ((m_complete_wr || s_complete_wr) && in_flight_q[i] && complete_id == 8'(i)) begin
                in_flight_d[i] = 1'b0;
            end
            // Only one claim register is addressed per cycle; ID 0 matches nothing.
            if ((m_claim_rd && m_claim_id == 8'(i)) || (s_claim_rd && s_claim_id == 8'(i))) begin
                pending_d[i]   = 1'b0;
                in_flight_d[i] = 1'b1;
            end
        end
        pending_d[0]   = 1'b0;
        in_flight_d[0] = 1'b0;

        if (writeEnable && offset == OffMEnable) begin
            m_enable_d = enable_write(m_enable_q, writeData, writeByteEnable);
        end
        if (writeEnable && offset == OffSEnable) begin
            s_enable_d = enable_write(s_enable_q, writeData, writeByteEnable);
        end
    end

    // Read mux from pre-write state, and registered interrupt outputs.
    always_comb begin
        read_data_d = read_data_q;
        if (readEnable) begin
            case (offset)
                OffPending: read_data_d = DATA_WIDTH'(pending_q);
                OffMEnable: read_data_d = DATA_WIDTH'(m_enable_q);
                OffSEnable: read_data_d = DATA_WIDTH'(s_enable_q);
                OffMClaim:  read_data_d = DATA_WIDTH'(m_claim_id);
                OffSClaim:  read_data_d = DATA_WIDTH'(s_claim_id);
                default:    read_data_d = '0;
            endcase
        end
        m_ext_d = |(pending_q & m_enable_q);
        s_ext_d = |(pending_q & s_enable_q);
    end

    // State registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending_q   <= '0;
            in_flight_q <= '0;
            m_enable_q  <= '0;
            s_enable_q  <= '0;
            read_data_q <= '0;
            m_ext_q     <= 1'b0;
            s_ext_q     <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            in_flight_q <= in_flight_d;
            m_enable_q  <= m_enable_d;
            s_enable_q  <= s_enable_d;
            read_data_q <= read_data_d;
            m_ext_q     <= m_ext_d;
            s_ext_q     <= s_ext_d;
        end
    end

    assign readData        = read_data_q;
    assign m_ext_interrupt = m_ext_q;
    assign s_ext_interrupt = s_ext_q;

endmodule
